// File: rtl/traffic_light_pkg.sv
// Shared lamp encodings, fault codes and monitor state type for the traffic-light blocks.
// Lamp vectors are {red, yellow, green}; exactly one bit set is a legal lamp command.
package traffic_light_pkg;

  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_INVALID      = 3'd1;
  localparam logic [2:0] FC_CONFLICT     = 3'd2;
  localparam logic [2:0] FC_SEQUENCE     = 3'd3;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;
  localparam logic [2:0] FC_STUCK        = 3'd5;

  typedef enum logic {
    ST_MONITOR = 1'b0,
    ST_FAULT   = 1'b1
  } mon_state_t;

  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == LAMP_GREEN) || (v == LAMP_YELLOW) || (v == LAMP_RED);
  endfunction

  // Legal per-direction steps: hold, red->green, green->yellow, yellow->red.
  function automatic logic is_legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return (prev == cur) ||
           ((prev == LAMP_RED)    && (cur == LAMP_GREEN))  ||
           ((prev == LAMP_GREEN)  && (cur == LAMP_YELLOW)) ||
           ((prev == LAMP_YELLOW) && (cur == LAMP_RED));
  endfunction

endpackage

// File: rtl/light_channel_check.sv
// Per-direction checker: remembers the previous lamp sample and the yellow dwell,
// and flags malformed commands, illegal steps and yellow phases that end too early.
module light_channel_check #(
  parameter int MIN_YELLOW = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_en,
  input  logic [2:0] i_sample,
  output logic [2:0] o_prev,
  output logic       o_invalid,
  output logic       o_sequence,
  output logic       o_short_yellow
);
  import traffic_light_pkg::*;

  localparam int CW = $clog2(MIN_YELLOW + 1);

  logic [2:0]    r_prev;
  logic [CW-1:0] r_ycnt;
  logic [CW-1:0] w_ycnt_next;

  always_comb begin
    o_invalid      = !is_one_hot3(i_sample);
    o_sequence     = !is_legal_step(r_prev, i_sample);
    o_short_yellow = (r_prev == LAMP_YELLOW) && (i_sample == LAMP_RED) &&
                     (r_ycnt < CW'(MIN_YELLOW));
  end

  // Counts consecutive yellow samples, saturating at MIN_YELLOW.
  always_comb begin
    w_ycnt_next = '0;
    if (i_sample == LAMP_YELLOW) begin
      if (r_prev != LAMP_YELLOW)
        w_ycnt_next = CW'(1);
      else if (r_ycnt == CW'(MIN_YELLOW))
        w_ycnt_next = r_ycnt;
      else
        w_ycnt_next = r_ycnt + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev <= LAMP_RED;
      r_ycnt <= '0;
    end else if (i_en) begin
      r_prev <= i_sample;
      r_ycnt <= w_ycnt_next;
    end
  end

  assign o_prev = r_prev;

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety monitor between a two-direction traffic controller and its lamps: passes commands
// through one cycle late, and on the first rule violation latches a fault and flashes red.
module light_conflict_monitor #(
  parameter int MIN_YELLOW = 2,
  parameter int MAX_HOLD   = 30,
  parameter int FLASH_HALF = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic [2:0] lamp_A,
  output logic [2:0] lamp_B,
  output logic       fault,
  output logic [2:0] fault_code
);
  import traffic_light_pkg::*;

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  mon_state_t    r_state, w_state_next;
  logic [2:0]    r_lamp_A, w_lamp_A_next;
  logic [2:0]    r_lamp_B, w_lamp_B_next;
  logic          r_fault, w_fault_next;
  logic [2:0]    r_fault_code, w_fault_code_next;
  logic [HW-1:0] r_hold, w_hold_next, w_hold_count;
  logic [FW-1:0] r_flash_cnt, w_flash_cnt_next;

  logic [2:0] w_sample [2];
  logic [2:0] w_prev   [2];
  logic [1:0] w_invalid, w_sequence, w_short;
  logic       w_monitor, w_conflict, w_changed, w_stuck;
  logic [2:0] w_code;

  assign w_sample[0] = A;
  assign w_sample[1] = B;
  assign w_monitor   = (r_state == ST_MONITOR);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      light_channel_check #(
        .MIN_YELLOW(MIN_YELLOW)
      ) u_check (
        .clock         (clock),
        .reset         (reset),
        .i_en          (w_monitor),
        .i_sample      (w_sample[gi]),
        .o_prev        (w_prev[gi]),
        .o_invalid     (w_invalid[gi]),
        .o_sequence    (w_sequence[gi]),
        .o_short_yellow(w_short[gi])
      );
    end
  endgenerate

  // Both directions showing anything but red at once is a conflict.
  assign w_conflict = !A[2] && !B[2];
  assign w_changed  = (A != w_prev[0]) || (B != w_prev[1]);

  always_comb begin
    w_hold_count = '0;
    if (!w_changed)
      w_hold_count = (r_hold == HW'(MAX_HOLD)) ? r_hold : r_hold + HW'(1);
  end

  assign w_stuck = (w_hold_count == HW'(MAX_HOLD));

  // Lowest code wins when several checks fail on the same sample.
  always_comb begin
    w_code = FC_NONE;
    if (|w_invalid)
      w_code = FC_INVALID;
    else if (w_conflict)
      w_code = FC_CONFLICT;
    else if (|w_sequence)
      w_code = FC_SEQUENCE;
    else if (|w_short)
      w_code = FC_SHORT_YELLOW;
    else if (w_stuck)
      w_code = FC_STUCK;
  end

  always_comb begin
    w_state_next      = r_state;
    w_lamp_A_next     = r_lamp_A;
    w_lamp_B_next     = r_lamp_B;
    w_fault_next      = r_fault;
    w_fault_code_next = r_fault_code;
    w_hold_next       = r_hold;
    w_flash_cnt_next  = r_flash_cnt;
    case (r_state)
      ST_MONITOR: begin
        w_lamp_A_next = A;
        w_lamp_B_next = B;
        w_hold_next   = w_hold_count;
        if (w_code != FC_NONE) begin
          w_state_next      = ST_FAULT;
          w_fault_next      = 1'b1;
          w_fault_code_next = w_code;
          w_lamp_A_next     = LAMP_RED;
          w_lamp_B_next     = LAMP_RED;
          w_flash_cnt_next  = '0;
        end
      end
      ST_FAULT: begin
        // Lamp A doubles as the flash phase; both directions always flash together.
        if (r_flash_cnt == FW'(FLASH_HALF - 1)) begin
          w_flash_cnt_next = '0;
          w_lamp_A_next    = (r_lamp_A == LAMP_RED) ? LAMP_OFF : LAMP_RED;
          w_lamp_B_next    = (r_lamp_A == LAMP_RED) ? LAMP_OFF : LAMP_RED;
        end else begin
          w_flash_cnt_next = r_flash_cnt + FW'(1);
        end
      end
      default: begin
        w_state_next = ST_MONITOR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_MONITOR;
      r_lamp_A     <= LAMP_RED;
      r_lamp_B     <= LAMP_RED;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
      r_hold       <= '0;
      r_flash_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_lamp_A     <= w_lamp_A_next;
      r_lamp_B     <= w_lamp_B_next;
      r_fault      <= w_fault_next;
      r_fault_code <= w_fault_code_next;
      r_hold       <= w_hold_next;
      r_flash_cnt  <= w_flash_cnt_next;
    end
  end

  assign lamp_A     = r_lamp_A;
  assign lamp_B     = r_lamp_B;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Scoreboard bench for light_conflict_monitor: a behavioural reference model predicts each
// cycle's outputs, and directed scenarios additionally check the fault codes they provoke.
module tb_light_conflict_monitor;

  localparam int MIN_YELLOW = 2;
  localparam int MAX_HOLD   = 30;
  localparam int FLASH_HALF = 1;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] A = 3'b100;
  logic [2:0] B = 3'b100;
  logic [2:0] lamp_A, lamp_B;
  logic       fault;
  logic [2:0] fault_code;

  always #5 clock = ~clock;

  light_conflict_monitor #(
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_HOLD  (MAX_HOLD),
    .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .lamp_A    (lamp_A),
    .lamp_B    (lamp_B),
    .fault     (fault),
    .fault_code(fault_code)
  );

  typedef struct packed {
    logic [2:0] la;
    logic [2:0] lb;
    logic       f;
    logic [2:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;

  // Reference model state
  logic [2:0] m_la, m_lb, m_pa, m_pb;
  bit         m_f;
  int         m_fc, m_ya, m_yb, m_hold, m_fcnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit onehot(input logic [2:0] v);
    return (v == R) || (v == Y) || (v == G);
  endfunction

  function automatic bit step_ok(input logic [2:0] p, input logic [2:0] c);
    if (p == c) return 1'b1;
    if (p == R && c == G) return 1'b1;
    if (p == G && c == Y) return 1'b1;
    if (p == Y && c == R) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int next_yellow(input logic [2:0] p, input logic [2:0] c, input int y);
    if (c != Y) return 0;
    if (p != Y) return 1;
    return (y + 1 > MIN_YELLOW) ? MIN_YELLOW : y + 1;
  endfunction

  task automatic model_step(input bit rst, input logic [2:0] a, input logic [2:0] b);
    int  code;
    int  hold;
    if (rst) begin
      m_la = R; m_lb = R; m_f = 1'b0; m_fc = 0;
      m_pa = R; m_pb = R; m_ya = 0; m_yb = 0; m_hold = 0; m_fcnt = 0;
      return;
    end
    if (m_f) begin
      m_fcnt++;
      if (m_fcnt == FLASH_HALF) begin
        m_fcnt = 0;
        m_la = (m_la == R) ? OFF : R;
        m_lb = m_la;
      end
      return;
    end
    hold = ((a != m_pa) || (b != m_pb)) ? 0 : m_hold + 1;
    if (hold > MAX_HOLD) hold = MAX_HOLD;
    code = 0;
    if (!onehot(a) || !onehot(b))                      code = 1;
    else if (a != R && b != R)                         code = 2;
    else if (!step_ok(m_pa, a) || !step_ok(m_pb, b))   code = 3;
    else if ((m_pa == Y && a == R && m_ya < MIN_YELLOW) ||
             (m_pb == Y && b == R && m_yb < MIN_YELLOW)) code = 4;
    else if (hold == MAX_HOLD)                         code = 5;
    m_ya = next_yellow(m_pa, a, m_ya);
    m_yb = next_yellow(m_pb, b, m_yb);
    m_pa = a; m_pb = b; m_hold = hold;
    if (code != 0) begin
      m_f = 1'b1; m_fc = code; m_la = R; m_lb = R; m_fcnt = 0;
    end else begin
      m_la = a; m_lb = b;
    end
  endtask

  task automatic step(input bit rst, input logic [2:0] a, input logic [2:0] b);
    exp_t e;
    @(negedge clock);
    reset = rst; A = a; B = b;
    model_step(rst, a, b);
    e.la = m_la; e.lb = m_lb; e.f = m_f; e.fc = m_fc[2:0];
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    check_val("lamp_A", lamp_A, e.la);
    check_val("lamp_B", lamp_B, e.lb);
    check_val("fault", fault, e.f);
    check_val("fault_code", fault_code, e.fc);
    n_txn++;
    $display("txn %0d rst=%0b A=%b B=%b -> lamp_A=%b lamp_B=%b fault=%0b code=%0d",
             n_txn, rst, a, b, lamp_A, lamp_B, fault, fault_code);
  endtask

  initial begin
    logic [2:0] ta, tb;
    int ph;

    // Reset held for two ticks, then a legal controller cycle for 60 s.
    step(1'b1, R, R);
    check_val("rst_lamp_A", lamp_A, R);
    check_val("rst_fault", fault, 0);
    check_val("rst_code", fault_code, 0);
    step(1'b1, R, R);
    for (int t = 0; t < 60; t++) begin
      ph = t % 15;
      if (ph < 5)       begin ta = G; tb = R; end
      else if (ph < 7)  begin ta = Y; tb = R; end
      else if (ph < 12) begin ta = R; tb = G; end
      else              begin ta = R; tb = Y; end
      step(1'b0, ta, tb);
    end
    check_val("run_fault", fault, 0);

    // Both green: conflict, then red/off flash; later faults must not overwrite the code.
    step(1'b1, R, R);
    step(1'b0, G, G);
    check_val("conf_code", fault_code, 2);
    check_val("conf_lamp0", lamp_A, R);
    step(1'b0, 3'b110, G);
    check_val("conf_lamp1", lamp_B, OFF);
    step(1'b0, R, R);
    check_val("conf_lamp2", lamp_A, R);
    step(1'b0, G, G);
    check_val("conf_hold", fault_code, 2);

    // Yellow for a single sample before red.
    step(1'b1, R, R);
    step(1'b0, G, R);
    step(1'b0, Y, R);
    step(1'b0, R, R);
    check_val("short_y_code", fault_code, 4);

    // Yellow for exactly MIN_YELLOW samples is accepted.
    step(1'b1, R, R);
    step(1'b0, R, G);
    step(1'b0, R, Y);
    step(1'b0, R, Y);
    step(1'b0, R, R);
    check_val("ok_y_fault", fault, 0);

    // Green straight to red.
    step(1'b1, R, R);
    step(1'b0, G, R);
    step(1'b0, R, R);
    check_val("seq_code", fault_code, 3);

    // Not one-hot.
    step(1'b1, R, R);
    step(1'b0, 3'b110, R);
    check_val("inv_code", fault_code, 1);

    // Yellow as first sample after reset.
    step(1'b1, R, R);
    step(1'b0, R, Y);
    check_val("first_y_code", fault_code, 3);

    // Simultaneous failures: invalid beats conflict, conflict beats sequence.
    step(1'b1, R, R);
    step(1'b0, 3'b011, G);
    check_val("prio_inv", fault_code, 1);
    step(1'b1, R, R);
    step(1'b0, Y, G);
    check_val("prio_conf", fault_code, 2);

    // Stuck controller: one change then 30 unchanged samples; reset mid-flash.
    step(1'b1, R, R);
    step(1'b0, R, G);
    for (int i = 1; i < MAX_HOLD; i++) step(1'b0, R, G);
    check_val("stuck_pre", fault, 0);
    step(1'b0, R, G);
    check_val("stuck_code", fault_code, 5);
    step(1'b0, R, G);
    step(1'b0, R, G);
    step(1'b0, R, G);
    check_val("stuck_flash", lamp_A, OFF);
    step(1'b1, R, G);
    check_val("rst_mid_lamp", lamp_A, R);
    check_val("rst_mid_fault", fault, 0);
    step(1'b0, R, G);
    check_val("post_rst_lamp_B", lamp_B, G);

    check_val("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
